// File: rtl/bch_chien_search_pkg.sv
// Shared GF(2^m) definitions for the BCH Chien search stage: default
// parameters, common types and constant Galois-field helper functions.
package bch_chien_search_pkg;

  localparam int M_DEF = 8;
  localparam int T_DEF = 8;
  localparam int MAX_M = 16;
  localparam int PTR_W = 4;

  typedef logic [PTR_W-1:0] ptr_t;
  typedef logic [MAX_M-1:0] gf_word_t;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_SEARCH = 1'b1
  } state_t;

  // Low-order terms of the primitive polynomial for GF(2^mm); the x^mm term is implicit.
  function automatic gf_word_t gf_prim_poly(input int mm);
    gf_word_t p;
    case (mm)
      3:       p = 16'h0003;  // x^3+x+1
      4:       p = 16'h0003;  // x^4+x+1
      5:       p = 16'h0005;  // x^5+x^2+1
      6:       p = 16'h0003;  // x^6+x+1
      7:       p = 16'h0009;  // x^7+x^3+1
      9:       p = 16'h0011;  // x^9+x^4+1
      10:      p = 16'h0009;  // x^10+x^3+1
      11:      p = 16'h0005;  // x^11+x^2+1
      12:      p = 16'h0053;  // x^12+x^6+x^4+x+1
      13:      p = 16'h001B;  // x^13+x^4+x^3+x+1
      14:      p = 16'h0443;  // x^14+x^10+x^6+x+1
      15:      p = 16'h0003;  // x^15+x+1
      16:      p = 16'h100B;  // x^16+x^12+x^3+x+1
      default: p = 16'h001D;  // x^8+x^4+x^3+x^2+1
    endcase
    return p;
  endfunction

  // Shift-and-add product in GF(2^mm); with a constant b it reduces to an XOR network.
  function automatic gf_word_t gf_mult_a_by_b(input gf_word_t a, input gf_word_t b, input int mm);
    gf_word_t mask;
    gf_word_t hibit;
    gf_word_t poly;
    gf_word_t aa;
    gf_word_t bb;
    gf_word_t p;
    logic     carry;
    mask  = (gf_word_t'(1) << mm) - gf_word_t'(1);
    hibit = gf_word_t'(1) << (mm - 1);
    poly  = gf_prim_poly(mm);
    aa    = a & mask;
    bb    = b;
    p     = '0;
    for (int i = 0; i < MAX_M; i++) begin
      if (i < mm) begin
        if (bb[0]) p = p ^ aa;
        carry = |(aa & hibit);
        aa    = (aa << 1) & mask;
        if (carry) aa = aa ^ poly;
        bb    = bb >> 1;
      end
    end
    return p;
  endfunction

  // alpha^e in GF(2^mm); intended for elaboration-time constants only.
  function automatic gf_word_t gf_alpha_pow(input int e, input int mm);
    gf_word_t p;
    p = gf_word_t'(1);
    for (int k = 0; k < e; k++) p = gf_mult_a_by_b(p, gf_word_t'(2), mm);
    return p;
  endfunction

endpackage

// File: rtl/bch_chien_search_if.sv
// Link between the Berlekamp stage and the Chien search: locator polynomial
// handshake in, per-position error-flag stream and frame verdict out.
interface bch_chien_search_if import bch_chien_search_pkg::*; #(
  parameter int m = M_DEF,
  parameter int t = T_DEF
);

  localparam int CW = $clog2(t + 2);

  logic                  iloc_poly_val;
  logic [0:t][m-1:0]     iloc_poly;
  ptr_t                  iloc_poly_ptr;
  logic                  iloc_failed;
  logic                  ordy;
  logic                  oval;
  logic                  osop;
  logic                  oeop;
  logic                  oerr;
  ptr_t                  optr;
  logic [CW-1:0]         oerr_cnt;
  logic                  odecfail;

  // Upstream / stimulus side.
  modport master (
    output iloc_poly_val, iloc_poly, iloc_poly_ptr, iloc_failed,
    input  ordy, oval, osop, oeop, oerr, optr, oerr_cnt, odecfail
  );

  // Chien search side.
  modport slave (
    input  iloc_poly_val, iloc_poly, iloc_poly_ptr, iloc_failed,
    output ordy, oval, osop, oeop, oerr, optr, oerr_cnt, odecfail
  );

endinterface

// File: rtl/bch_chien_search_cell.sv
// One Chien term register r_j: loads Lambda_j*alpha^j on accept and is
// multiplied by the constant alpha^j on every evaluated position.
module bch_chien_cell import bch_chien_search_pkg::*; #(
  parameter int m = M_DEF,
  parameter int j = 0
) (
  input  logic         iclk,
  input  logic         iload,
  input  logic         ienable,
  input  logic [m-1:0] icoef,
  output logic [m-1:0] onext
);

  localparam gf_word_t ALPHA_J = gf_alpha_pow(j, m);

  logic [m-1:0] r_q;

  // Next term value; a single constant multiplier serves both load and step.
  always_comb begin
    onext = m'(gf_mult_a_by_b(gf_word_t'(iload ? icoef : r_q), ALPHA_J, m));
  end

  // Term register update.
  // NOTE: datapath register deliberately has no reset; it is always reloaded on accept before use.
  always_ff @(posedge iclk) begin
    if (ienable) r_q <= onext;
  end

endmodule

// File: rtl/bch_chien_search.sv
// Chien search: evaluates the locator polynomial at every codeword position,
// highest position first, and reports root count and decode failure per frame.
// Outputs are fully registered: each cycle computes the position shown next cycle.
module bch_chien_search import bch_chien_search_pkg::*; #(
  parameter int m = M_DEF,
  parameter int n = (1 << m) - 1,
  parameter int t = T_DEF
) (
  input  logic               iclk,
  input  logic               ireset,
  bch_chien_search_if.slave  bus
);

  typedef logic [m-1:0] data_t;

  localparam int CW = $clog2(t + 2);
  localparam int PW = $clog2(n);

  state_t        state, state_nx;
  logic [PW-1:0] c, c_nx;
  logic          last, rdy, accept, eval;

  data_t         next_r  [0:t];
  data_t         xor_acc [0:t+1];
  logic [t:0]    nz;
  data_t         syn;
  logic          root;

  logic          fail_q, lam0_q;
  logic [CW-1:0] deg_q, cnt_q;
  logic          lam0_in, fail_n, lam0_n;
  logic [CW-1:0] deg_in, deg_n, cnt_base, cnt_sum;
  logic          eop_nx;

  // Term registers and the XOR tree giving Lambda at the position computed this cycle.
  assign xor_acc[0] = '0;
  for (genvar j = 0; j <= t; j++) begin : g_cell
    bch_chien_cell #(.m(m), .j(j)) u_cell (
      .iclk    (iclk),
      .iload   (accept),
      .ienable (eval),
      .icoef   (bus.iloc_poly[j]),
      .onext   (next_r[j])
    );
    assign xor_acc[j+1] = xor_acc[j] ^ next_r[j];
    assign nz[j]        = |bus.iloc_poly[j];
  end
  assign syn  = xor_acc[t+1];
  assign root = (syn == '0);

  // State and position register.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge iclk) begin
    if (ireset) begin
      state <= ST_IDLE;
      c     <= '0;
    end else begin
      state <= state_nx;
      c     <= c_nx;
    end
  end

  // Next state: stay in SEARCH across a back-to-back accept, otherwise leave after position 0.
  // NOTE: defaults first so no path leaves a combinational output unassigned (no latch).
  always_comb begin
    state_nx = state;
    c_nx     = c;
    unique case (state)
      ST_IDLE: begin
        if (accept) begin
          state_nx = ST_SEARCH;
          c_nx     = '0;
        end
      end
      ST_SEARCH: begin
        if (accept) begin
          c_nx = '0;
        end else if (last) begin
          state_nx = ST_IDLE;
          c_nx     = '0;
        end else begin
          c_nx = c + PW'(1);
        end
      end
    endcase
  end

  // FSM outputs: ready, accept and whether a position is evaluated this cycle.
  always_comb begin
    last     = (state == ST_SEARCH) && (c == PW'(n - 1));
    rdy      = (state == ST_IDLE) || last;
    accept   = bus.iloc_poly_val && rdy && !ireset;
    eval     = accept || ((state == ST_SEARCH) && !last);
    bus.ordy = rdy;
  end

  // Frame attributes for the position computed now: fresh on accept, latched otherwise.
  always_comb begin
    logic [t:0] nzv;
    deg_in = '0;
    nzv    = nz;
    for (int j = 0; j <= t; j++) begin
      if (nzv[0]) deg_in = CW'(j);
      nzv = nzv >> 1;
    end
    lam0_in  = ~nz[0];
    fail_n   = accept ? bus.iloc_failed : fail_q;
    lam0_n   = accept ? lam0_in : lam0_q;
    deg_n    = accept ? deg_in : deg_q;
    cnt_base = accept ? '0 : cnt_q;
    cnt_sum  = (cnt_base == CW'(t + 1)) ? cnt_base : cnt_base + CW'(root);
    eop_nx   = eval && (c_nx == PW'(n - 1));
  end

  // Registered output stream, frame latches and end-of-frame verdict.
  always_ff @(posedge iclk) begin
    if (ireset) begin
      bus.oval     <= 1'b0;
      bus.osop     <= 1'b0;
      bus.oeop     <= 1'b0;
      bus.oerr     <= 1'b0;
      bus.optr     <= '0;
      bus.oerr_cnt <= '0;
      bus.odecfail <= 1'b0;
      fail_q       <= 1'b0;
      lam0_q       <= 1'b0;
      deg_q        <= '0;
      cnt_q        <= '0;
    end else begin
      bus.oval <= eval;
      bus.osop <= accept;
      bus.oeop <= eop_nx;
      bus.oerr <= eval && root && !fail_n && !lam0_n;
      if (accept) begin
        bus.optr <= bus.iloc_poly_ptr;
        fail_q   <= bus.iloc_failed;
        lam0_q   <= lam0_in;
        deg_q    <= deg_in;
      end
      if (eval) cnt_q <= cnt_sum;
      if (eop_nx) begin
        bus.oerr_cnt <= cnt_sum;
        bus.odecfail <= fail_n || lam0_n || (cnt_sum != deg_n);
      end
    end
  end

endmodule
